// File: rtl/angle_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// angle_sequencer_pkg
// Shared definitions for the ray-direction sequencer:
//   - frame FSM state encoding
//   - bit positions of the fields inside an 80-bit angle_rom word
//   - Q8.8 word width, ROM address width, default heading count
//   - heading_wrap_step(): one modulo step of the heading index
// -----------------------------------------------------------------------------
package angle_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_RAYS  = 2'd3
    } seq_state_e;

    localparam int Q_W            = 16;
    localparam int ADDR_W         = 7;
    localparam int ROM_W          = 80;
    localparam int NUM_ANGLES_DEF = 126;

    localparam int DIRX_HI   = 79;
    localparam int DIRX_LO   = 64;
    localparam int DIRY_HI   = 63;
    localparam int DIRY_LO   = 48;
    localparam int PLANEX_HI = 47;
    localparam int PLANEX_LO = 32;
    localparam int PLANEY_HI = 31;
    localparam int PLANEY_LO = 16;
    localparam int INVDET_HI = 15;
    localparam int INVDET_LO = 0;

    // One heading step with wrap-around; both or neither direction means no move.
    function automatic logic [ADDR_W-1:0] heading_wrap_step(
        input logic [ADDR_W-1:0] cur,
        input logic              step_left,
        input logic              step_right,
        input logic [ADDR_W-1:0] last_idx
    );
        logic [ADDR_W-1:0] nxt;
        nxt = cur;
        if (step_left && !step_right) begin
            if (cur == {ADDR_W{1'b0}}) begin
                nxt = last_idx;
            end else begin
                nxt = cur - {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end else if (step_right && !step_left) begin
            if (cur == last_idx) begin
                nxt = {ADDR_W{1'b0}};
            end else begin
                nxt = cur + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/angle_sequencer_heading_ctrl.sv
// -----------------------------------------------------------------------------
// heading_ctrl
// Owns the player heading index. Turn requests are collected into a pending
// register and applied (at most one step) when the frame FSM accepts a frame.
//
// Configuration macro: ANGLE_SEQ_AUTOREPEAT_EN
//   defined   : turn inputs are level-sensitive (held turn steps every frame)
//   undefined : turn inputs are rising-edge detected (one step per press)
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   turn_left      request heading - 1
//   turn_right     request heading + 1
//   apply          frame accepted this cycle: commit the pending turn
//   heading        current heading index (registered)
//   heading_next   heading value that an apply in this cycle will commit
// -----------------------------------------------------------------------------
module heading_ctrl
    import angle_sequencer_pkg::*;
#(
    parameter int NUM_ANGLES   = NUM_ANGLES_DEF,
    parameter int INIT_HEADING = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              turn_left,
    input  logic              turn_right,
    input  logic              apply,
    output logic [ADDR_W-1:0] heading,
    output logic [ADDR_W-1:0] heading_next
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ANGLES - 1);
    localparam logic [ADDR_W-1:0] INIT_IDX = ADDR_W'(INIT_HEADING);

    logic              left_evt_s;
    logic              right_evt_s;
    logic              eff_left_s;
    logic              eff_right_s;
    logic              pend_left_r;
    logic              pend_right_r;
    logic [ADDR_W-1:0] heading_r;

`ifdef ANGLE_SEQ_AUTOREPEAT_EN
    assign left_evt_s  = turn_left;
    assign right_evt_s = turn_right;
`else
    logic left_prev_r;
    logic right_prev_r;

    // Previous-value flops for rising-edge detection of the turn inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_prev_r  <= 1'b0;
            right_prev_r <= 1'b0;
        end else begin
            left_prev_r  <= turn_left;
            right_prev_r <= turn_right;
        end
    end

    assign left_evt_s  = turn_left  & ~left_prev_r;
    assign right_evt_s = turn_right & ~right_prev_r;
`endif

    // A request arriving in the apply cycle itself is honoured in that frame.
    assign eff_left_s   = pend_left_r  | left_evt_s;
    assign eff_right_s  = pend_right_r | right_evt_s;
    assign heading_next = heading_wrap_step(heading_r, eff_left_s, eff_right_s, LAST_IDX);
    assign heading      = heading_r;

    // Pending-turn capture and heading commit on frame acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_left_r  <= 1'b0;
            pend_right_r <= 1'b0;
            heading_r    <= INIT_IDX;
        end else if (apply) begin
            pend_left_r  <= 1'b0;
            pend_right_r <= 1'b0;
            heading_r    <= heading_next;
        end else begin
            pend_left_r  <= eff_left_s;
            pend_right_r <= eff_right_s;
            heading_r    <= heading_r;
        end
    end

endmodule

// File: rtl/angle_sequencer.sv
// -----------------------------------------------------------------------------
// angle_sequencer
// Sequences one frame of ray-direction generation: commits the pending turn,
// fetches the heading's angle_rom entry, then streams one Q8.8 ray direction
// per screen column over a valid/ready handshake.
//
// Configuration macro: ANGLE_SEQ_AUTOREPEAT_EN (see heading_ctrl): selects
// level-sensitive (autorepeat) versus edge-detected turn inputs.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   frame_start           one-cycle pulse, honoured only while idle
//   turn_left/turn_right  turn requests
//   rom_addr              angle_rom address (registered)
//   rom_angle             angle_rom data, one cycle after rom_addr
//   ray_valid/ray_ready   ray handshake
//   ray_dir_x/ray_dir_y   ray direction, Q8.8 signed
//   ray_col               column of the presented ray
//   ray_last              presented ray is the last column
//   inv_det               invDet latched for the current frame
//   heading               current heading index
//   busy                  frame in progress
// -----------------------------------------------------------------------------
module angle_sequencer
    import angle_sequencer_pkg::*;
#(
    parameter int SCREEN_W     = 256,
    parameter int COL_SHIFT    = 8,
    parameter int NUM_ANGLES   = NUM_ANGLES_DEF,
    parameter int INIT_HEADING = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 turn_left,
    input  logic                 turn_right,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [ROM_W-1:0]     rom_angle,
    output logic                 ray_valid,
    input  logic                 ray_ready,
    output logic [Q_W-1:0]       ray_dir_x,
    output logic [Q_W-1:0]       ray_dir_y,
    output logic [COL_SHIFT-1:0] ray_col,
    output logic                 ray_last,
    output logic [Q_W-1:0]       inv_det,
    output logic [ADDR_W-1:0]    heading,
    output logic                 busy
);

    // 17 bits hold dir +/- plane exactly; COL_SHIFT more bits keep the
    // per-column sum exact so the output slice is a true floor of acc/W.
    localparam int                   ACC_W    = 17 + COL_SHIFT;
    localparam logic [COL_SHIFT-1:0] LAST_COL = COL_SHIFT'(SCREEN_W - 1);
    localparam logic [ADDR_W-1:0]    INIT_IDX = ADDR_W'(INIT_HEADING);

    seq_state_e                state_r;
    logic [ADDR_W-1:0]         rom_addr_r;
    logic                      ray_valid_r;
    logic                      busy_r;
    logic [COL_SHIFT-1:0]      ray_col_r;
    logic [Q_W-1:0]            inv_det_r;
    logic signed [ACC_W-1:0]   acc_x_r;
    logic signed [ACC_W-1:0]   acc_y_r;
    logic signed [ACC_W-1:0]   step_x_r;
    logic signed [ACC_W-1:0]   step_y_r;

    logic                      accept_s;
    logic                      fire_s;
    logic                      last_s;
    logic [ADDR_W-1:0]         heading_next_s;
    logic signed [ACC_W-1:0]   dir_x_ext_s;
    logic signed [ACC_W-1:0]   dir_y_ext_s;
    logic signed [ACC_W-1:0]   plane_x_ext_s;
    logic signed [ACC_W-1:0]   plane_y_ext_s;

    assign accept_s = (state_r == ST_IDLE) && frame_start;
    assign last_s   = (state_r == ST_RAYS) && (ray_col_r == LAST_COL);
    assign fire_s   = ray_valid_r && ray_ready;

    assign dir_x_ext_s   = ACC_W'($signed(rom_angle[DIRX_HI:DIRX_LO]));
    assign dir_y_ext_s   = ACC_W'($signed(rom_angle[DIRY_HI:DIRY_LO]));
    assign plane_x_ext_s = ACC_W'($signed(rom_angle[PLANEX_HI:PLANEX_LO]));
    assign plane_y_ext_s = ACC_W'($signed(rom_angle[PLANEY_HI:PLANEY_LO]));

    heading_ctrl #(
        .NUM_ANGLES   (NUM_ANGLES),
        .INIT_HEADING (INIT_HEADING)
    ) u_heading_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .turn_left    (turn_left),
        .turn_right   (turn_right),
        .apply        (accept_s),
        .heading      (heading),
        .heading_next (heading_next_s)
    );

    // Frame FSM with ROM address, accumulators and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rom_addr_r  <= INIT_IDX;
            ray_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            ray_col_r   <= {COL_SHIFT{1'b0}};
            inv_det_r   <= {Q_W{1'b0}};
            acc_x_r     <= {ACC_W{1'b0}};
            acc_y_r     <= {ACC_W{1'b0}};
            step_x_r    <= {ACC_W{1'b0}};
            step_y_r    <= {ACC_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (frame_start) begin
                        rom_addr_r <= heading_next_s;
                        busy_r     <= 1'b1;
                        state_r    <= ST_FETCH;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_LOAD;
                end
                ST_LOAD: begin
                    inv_det_r   <= rom_angle[INVDET_HI:INVDET_LO];
                    acc_x_r     <= (dir_x_ext_s - plane_x_ext_s) <<< COL_SHIFT;
                    acc_y_r     <= (dir_y_ext_s - plane_y_ext_s) <<< COL_SHIFT;
                    step_x_r    <= plane_x_ext_s <<< 1;
                    step_y_r    <= plane_y_ext_s <<< 1;
                    ray_col_r   <= {COL_SHIFT{1'b0}};
                    ray_valid_r <= 1'b1;
                    state_r     <= ST_RAYS;
                end
                ST_RAYS: begin
                    if (fire_s) begin
                        acc_x_r   <= acc_x_r + step_x_r;
                        acc_y_r   <= acc_y_r + step_y_r;
                        ray_col_r <= ray_col_r + {{(COL_SHIFT-1){1'b0}}, 1'b1};
                        if (last_s) begin
                            ray_valid_r <= 1'b0;
                            busy_r      <= 1'b0;
                            state_r     <= ST_IDLE;
                        end else begin
                            state_r     <= ST_RAYS;
                        end
                    end else begin
                        state_r <= ST_RAYS;
                    end
                end
                default: begin
                    ray_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom_addr  = rom_addr_r;
    assign ray_valid = ray_valid_r;
    assign busy      = busy_r;
    assign ray_col   = ray_col_r;
    assign ray_last  = last_s;
    assign inv_det   = inv_det_r;
    assign ray_dir_x = acc_x_r[COL_SHIFT+Q_W-1:COL_SHIFT];
    assign ray_dir_y = acc_y_r[COL_SHIFT+Q_W-1:COL_SHIFT];

endmodule

// File: tb/tb_angle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_angle_sequencer
// Self-checking bench: a behavioural angle_rom, a scoreboard of expected rays
// filled from the closed-form floor((dir*W + (2k-W)*plane)/W), and scenario
// tasks for reset, turns, backpressure, ignored frame_start and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_angle_sequencer;

    localparam int W      = 256;
    localparam int CS     = 8;
    localparam int NA     = 126;
    localparam int INIT_H = 0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start;
    logic          turn_left;
    logic          turn_right;
    logic [6:0]    rom_addr;
    logic [79:0]   rom_angle;
    logic          ray_valid;
    logic          ray_ready;
    logic [15:0]   ray_dir_x;
    logic [15:0]   ray_dir_y;
    logic [CS-1:0] ray_col;
    logic          ray_last;
    logic [15:0]   inv_det;
    logic [6:0]    heading;
    logic          busy;

    typedef struct {
        logic [15:0]   dx;
        logic [15:0]   dy;
        logic [CS-1:0] col;
        logic          last;
    } ray_t;

    ray_t        sb_q[$];
    logic [79:0] rom_mem [0:127];
    logic [15:0] seen_dy [0:W-1];
    logic [15:0] exp_inv_det;
    int          errors = 0;
    int          checks = 0;
    int          exp_heading;

    angle_sequencer #(
        .SCREEN_W     (W),
        .COL_SHIFT    (CS),
        .NUM_ANGLES   (NA),
        .INIT_HEADING (INIT_H)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .turn_left   (turn_left),
        .turn_right  (turn_right),
        .rom_addr    (rom_addr),
        .rom_angle   (rom_angle),
        .ray_valid   (ray_valid),
        .ray_ready   (ray_ready),
        .ray_dir_x   (ray_dir_x),
        .ray_dir_y   (ray_dir_y),
        .ray_col     (ray_col),
        .ray_last    (ray_last),
        .inv_det     (inv_det),
        .heading     (heading),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // angle_rom model: one-cycle registered read.
    always @(posedge clk) rom_angle <= rom_mem[rom_addr];

    function automatic logic [15:0] ray_comp(input logic [15:0] dir, input logic [15:0] plane, input int k);
        longint d;
        longint p;
        longint num;
        longint q;
        d   = $signed(dir);
        p   = $signed(plane);
        num = d * W + (2 * k - W) * p;
        q   = num >>> CS;
        return q[15:0];
    endfunction

    task automatic push_frame(input int hd);
        logic [79:0] ent;
        ent = rom_mem[hd];
        exp_inv_det = ent[15:0];
        for (int k = 0; k < W; k++) begin
            ray_t r;
            r.dx   = ray_comp(ent[79:64], ent[47:32], k);
            r.dy   = ray_comp(ent[63:48], ent[31:16], k);
            r.col  = CS'(k);
            r.last = (k == W - 1);
            sb_q.push_back(r);
        end
    endtask

    // Output monitor: scoreboard pop on each handshake, stability while stalled.
    initial begin : monitor
        logic          prev_stall;
        logic [15:0]   prev_dx;
        logic [15:0]   prev_dy;
        logic [CS-1:0] prev_col;
        prev_stall = 1'b0;
        prev_dx    = 16'h0000;
        prev_dy    = 16'h0000;
        prev_col   = {CS{1'b0}};
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (ray_valid !== 1'b1 || ray_dir_x !== prev_dx || ray_dir_y !== prev_dy || ray_col !== prev_col) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%0b dx=%h dy=%h col=%0d, want v=1 dx=%h dy=%h col=%0d",
                                 ray_valid, ray_dir_x, ray_dir_y, ray_col, prev_dx, prev_dy, prev_col);
                    end
                end
                if (ray_valid === 1'b1 && ray_ready === 1'b1) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_ray: got col=%0d, want no ray", ray_col);
                    end else begin
                        ray_t e;
                        e = sb_q.pop_front();
                        if (ray_dir_x !== e.dx || ray_dir_y !== e.dy || ray_col !== e.col || ray_last !== e.last) begin
                            errors++;
                            $display("FAIL ray_out: got dx=%h dy=%h col=%0d last=%0b, want dx=%h dy=%h col=%0d last=%0b",
                                     ray_dir_x, ray_dir_y, ray_col, ray_last, e.dx, e.dy, e.col, e.last);
                        end
                        seen_dy[ray_col] = ray_dir_y;
                    end
                    checks++;
                    if (inv_det !== exp_inv_det) begin
                        errors++;
                        $display("FAIL inv_det: got %h, want %h", inv_det, exp_inv_det);
                    end
                end
                prev_stall = (ray_valid === 1'b1 && ray_ready === 1'b0);
                prev_dx    = ray_dir_x;
                prev_dy    = ray_dir_y;
                prev_col   = ray_col;
            end
        end
    end

    task automatic run_frame(input int hd, input bit rand_ready, input bit mid_pulse);
        int cyc;
        push_frame(hd);
        ray_ready   = 1'b1;
        frame_start = 1'b1;
        cyc = 0;
        @(posedge clk); #1; cyc = 1;
        frame_start = 1'b0;
        checks++;
        if (rom_addr !== 7'(hd) || heading !== 7'(hd)) begin
            errors++;
            $display("FAIL frame_heading: got rom_addr=%0d heading=%0d, want %0d", rom_addr, heading, hd);
        end
        checks++;
        if (busy !== 1'b1 || ray_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_cycle1: got busy=%0b valid=%0b, want busy=1 valid=0", busy, ray_valid);
        end
        @(posedge clk); #1; cyc = 2;
        checks++;
        if (ray_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_valid: got valid=%0b at cycle 2, want 0", ray_valid);
        end
        @(posedge clk); #1; cyc = 3;
        checks++;
        if (ray_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_valid: got valid=%0b at cycle 3, want 1", ray_valid);
        end
        while (busy === 1'b1 && cyc < 4 * W + 20) begin
            ray_ready   = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            frame_start = (mid_pulse && cyc == 20);
            @(posedge clk); #1; cyc++;
        end
        frame_start = 1'b0;
        ray_ready   = 1'b1;
        checks++;
        if (busy !== 1'b0 || ray_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_end: got busy=%0b valid=%0b after %0d cycles, want both 0", busy, ray_valid, cyc);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL rays_missing: got %0d rays still expected, want 0", sb_q.size());
            sb_q.delete();
        end
        if (!rand_ready) begin
            checks++;
            if (cyc != W + 3) begin
                errors++;
                $display("FAIL frame_length: got %0d cycles, want %0d", cyc, W + 3);
            end
        end
    endtask

    task automatic pulse_turn(input bit l, input bit r);
        @(posedge clk); #1;
        turn_left  = l;
        turn_right = r;
        @(posedge clk); #1;
        turn_left  = 1'b0;
        turn_right = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ray_valid !== 1'b0 || ray_last !== 1'b0 || busy !== 1'b0 || ray_col !== 8'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got valid=%0b last=%0b busy=%0b col=%0d, want all 0", ray_valid, ray_last, busy, ray_col);
        end
        checks++;
        if (ray_dir_x !== 16'h0000 || ray_dir_y !== 16'h0000 || inv_det !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: got dx=%h dy=%h inv=%h, want 0", ray_dir_x, ray_dir_y, inv_det);
        end
        checks++;
        if (heading !== 7'(INIT_H) || rom_addr !== 7'(INIT_H)) begin
            errors++;
            $display("FAIL reset_heading: got heading=%0d rom_addr=%0d, want %0d", heading, rom_addr, INIT_H);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_heading = INIT_H;
    endtask

    task automatic test_basic_frame();
        run_frame(exp_heading, 1'b0, 1'b0);
        checks++;
        if (seen_dy[0] !== 16'hFF58 || seen_dy[128] !== 16'h0000 || seen_dy[255] !== 16'h00A6) begin
            errors++;
            $display("FAIL basic_dy: got col0=%h col128=%h col255=%h, want ff58 0000 00a6",
                     seen_dy[0], seen_dy[128], seen_dy[255]);
        end
    endtask

    task automatic test_turns();
        pulse_turn(1'b1, 1'b0);
        exp_heading = NA - 1;
        run_frame(exp_heading, 1'b0, 1'b0);
        pulse_turn(1'b0, 1'b1);
        exp_heading = 0;
        run_frame(exp_heading, 1'b0, 1'b0);
    endtask

    task automatic test_cancel();
        pulse_turn(1'b1, 1'b1);
        run_frame(exp_heading, 1'b0, 1'b0);
        pulse_turn(1'b1, 1'b0);
        pulse_turn(1'b0, 1'b1);
        run_frame(exp_heading, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        pulse_turn(1'b0, 1'b1);
        exp_heading = 1;
        run_frame(exp_heading, 1'b1, 1'b0);
    endtask

    task automatic test_frame_start_mid();
        run_frame(exp_heading, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || ray_valid !== 1'b0) begin
                errors++;
                $display("FAIL ignored_start: got busy=%0b valid=%0b, want 0 0", busy, ray_valid);
            end
        end
    endtask

    task automatic test_hold_turn();
        @(posedge clk); #1;
        turn_right = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int f = 0; f < 3; f++) begin
`ifdef ANGLE_SEQ_AUTOREPEAT_EN
            exp_heading = exp_heading + 1;
`else
            if (f == 0) exp_heading = exp_heading + 1;
`endif
            run_frame(exp_heading, 1'b0, 1'b0);
        end
        turn_right = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`ifdef ANGLE_SEQ_AUTOREPEAT_EN
        // the last held cycles leave a request pending
        exp_heading = exp_heading + 1;
`endif
    endtask

    task automatic test_reset_mid_rays();
        push_frame(exp_heading);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (heading === 7'(INIT_H) || ray_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got heading=%0d valid=%0b, want heading!=%0d valid=1", heading, ray_valid, INIT_H);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ray_valid !== 1'b0 || ray_last !== 1'b0 || busy !== 1'b0 || ray_col !== 8'd0 ||
            ray_dir_x !== 16'h0000 || ray_dir_y !== 16'h0000 || inv_det !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset_out: got valid=%0b busy=%0b col=%0d dx=%h dy=%h inv=%h, want all 0",
                     ray_valid, busy, ray_col, ray_dir_x, ray_dir_y, inv_det);
        end
        checks++;
        if (heading !== 7'(INIT_H) || rom_addr !== 7'(INIT_H)) begin
            errors++;
            $display("FAIL mid_reset_heading: got heading=%0d rom_addr=%0d, want %0d", heading, rom_addr, INIT_H);
        end
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_heading = INIT_H;
        run_frame(exp_heading, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            if (i == 0) begin
                rom_mem[i] = {16'hFF00, 16'h0000, 16'h0000, 16'h00A8, 16'h0123};
            end else begin
                rom_mem[i] = {16'(i * 37 - 2000), 16'(i * 53), 16'(i * 11 - 500), 16'(300 - i * 7), 16'(i * 5 + 1)};
            end
        end
        for (int i = 0; i < W; i++) seen_dy[i] = 16'hDEAD;
        exp_inv_det = 16'h0000;
        exp_heading = INIT_H;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        turn_left   = 1'b0;
        turn_right  = 1'b0;
        ray_ready   = 1'b1;

        test_reset();
        test_basic_frame();
        test_turns();
        test_cancel();
        test_backpressure();
        test_frame_start_mid();
        test_hold_turn();
        test_reset_mid_rays();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
